// File: rtl/decoder_i_phase_sequencer_pkg.sv
// Shared constants for the DECODER_I tree: field widths, reset opcode, sequencer
// state encoding and the strobe bundle seen by the phase sequencer.
package decoder_i_phase_sequencer_pkg;

    localparam int XPT_W = 4;
    localparam int IT_W  = 8;

    localparam logic [IT_W-1:0]  NOP_OP  = 8'h00;
    localparam logic [XPT_W-1:0] XPT_MAX = '1;

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_EXEC  = 1'b1;

    typedef struct packed {
        logic reset_xpt;
        logic set_cm1;
        logic reset_itable;
        logic ophd;
    } dec_strobe_t;

    // Phase never wraps: a runaway instruction parks at the last phase.
    function automatic logic [XPT_W-1:0] xpt_sat_inc(input logic [XPT_W-1:0] x);
        return (x == XPT_MAX) ? x : x + 1'b1;
    endfunction

endpackage

// File: rtl/decoder_i_phase_sequencer_dual_rail_reg.sv
// Register with true and complemented outputs, both flopped from the same D
// so the two rails change on the same edge.
module decoder_i_phase_sequencer_dual_rail_reg #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q,
    output logic [W-1:0] o_q_n
);

    logic [W-1:0] r_q;
    logic [W-1:0] r_q_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q   <= RST_VAL;
            r_q_n <= ~RST_VAL;
        end else begin
            r_q   <= i_d;
            r_q_n <= ~i_d;
        end
    end

    assign o_q   = r_q;
    assign o_q_n = r_q_n;

endmodule

// File: rtl/decoder_i_phase_sequencer.sv
// Opcode fetch / execution-phase sequencer feeding the DECODER_I tree.
// state | meaning
// FETCH | opcode-fetch cycle (CM1), waiting for MEM_READY to latch DIN
// EXEC  | decoder enabled, XPT steps on each un-stalled, strobe-free cycle
module decoder_i_phase_sequencer
    import decoder_i_phase_sequencer_pkg::*;
(
    input  logic             CLK,
    input  logic             notRESET,
    input  logic [IT_W-1:0]  DIN,
    input  logic             MEM_READY,
    input  logic             PR_Reset_XPT,
    input  logic             P2_Set_CM1,
    input  logic             P2_Reset_ITABLE,
    input  logic             Pa_Ophd,
    output logic             FETCH_REQ,
    output logic             CM1,
    output logic             DEC_ENABLE,
    output logic [XPT_W-1:0] XPT,
    output logic [XPT_W-1:0] notXPT,
    output logic [IT_W-1:0]  ITABLE,
    output logic [IT_W-1:0]  notITABLE,
    output logic             XPT_OVF
);

    logic [0:0]       r_state;
    logic             r_ovf;

    logic [0:0]       w_state_d;
    logic             w_ovf_d;
    logic [XPT_W-1:0] w_xpt_d;
    logic [IT_W-1:0]  w_itable_d;
    dec_strobe_t      w_strb;
    logic             w_any_strobe;
    logic             w_inc;

    assign w_strb = '{reset_xpt:    PR_Reset_XPT,
                      set_cm1:      P2_Set_CM1,
                      reset_itable: P2_Reset_ITABLE,
                      ophd:         Pa_Ophd};

    assign w_any_strobe = |w_strb;
    assign w_inc        = (r_state == ST_EXEC) && MEM_READY && !w_any_strobe;

    always_comb begin
        w_state_d  = r_state;
        w_ovf_d    = r_ovf;
        w_xpt_d    = XPT;
        w_itable_d = ITABLE;
        case (r_state)
            ST_FETCH: begin
                // Decoder strobes are meaningless while fetching and are dropped.
                if (MEM_READY) begin
                    w_itable_d = DIN;
                    w_xpt_d    = '0;
                    w_state_d  = ST_EXEC;
                end
            end
            default: begin
                if (w_strb.reset_xpt) begin
                    w_xpt_d = '0;
                end else if (w_inc) begin
                    w_xpt_d = xpt_sat_inc(XPT);
                    if (XPT == XPT_MAX) begin
                        w_ovf_d = 1'b1;
                    end
                end
                if (w_strb.reset_itable) begin
                    w_itable_d = NOP_OP;
                end
                if (w_strb.set_cm1 || w_strb.ophd) begin
                    w_state_d = ST_FETCH;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) begin
            r_state <= ST_FETCH;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_ovf   <= w_ovf_d;
        end
    end

    decoder_i_phase_sequencer_dual_rail_reg #(
        .W       (XPT_W),
        .RST_VAL ('0)
    ) u_xpt_reg (
        .i_clk   (CLK),
        .i_rst_n (notRESET),
        .i_d     (w_xpt_d),
        .o_q     (XPT),
        .o_q_n   (notXPT)
    );

    decoder_i_phase_sequencer_dual_rail_reg #(
        .W       (IT_W),
        .RST_VAL (NOP_OP)
    ) u_itable_reg (
        .i_clk   (CLK),
        .i_rst_n (notRESET),
        .i_d     (w_itable_d),
        .o_q     (ITABLE),
        .o_q_n   (notITABLE)
    );

    assign CM1        = (r_state == ST_FETCH);
    assign FETCH_REQ  = (r_state == ST_FETCH);
    assign DEC_ENABLE = (r_state == ST_EXEC);
    assign XPT_OVF    = r_ovf;

endmodule

// File: tb/tb_decoder_i_phase_sequencer.sv
// Directed scenarios plus randomized traffic against a cycle-level reference
// model of the fetch/exec sequencer.
module tb_decoder_i_phase_sequencer;

    logic       CLK;
    logic       notRESET;
    logic [7:0] DIN;
    logic       MEM_READY;
    logic       PR_Reset_XPT;
    logic       P2_Set_CM1;
    logic       P2_Reset_ITABLE;
    logic       Pa_Ophd;
    logic       FETCH_REQ;
    logic       CM1;
    logic       DEC_ENABLE;
    logic [3:0] XPT;
    logic [3:0] notXPT;
    logic [7:0] ITABLE;
    logic [7:0] notITABLE;
    logic       XPT_OVF;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit         m_fetch;
    int         m_xpt;
    logic [7:0] m_it;
    bit         m_ovf;

    decoder_i_phase_sequencer dut (
        .CLK             (CLK),
        .notRESET        (notRESET),
        .DIN             (DIN),
        .MEM_READY       (MEM_READY),
        .PR_Reset_XPT    (PR_Reset_XPT),
        .P2_Set_CM1      (P2_Set_CM1),
        .P2_Reset_ITABLE (P2_Reset_ITABLE),
        .Pa_Ophd         (Pa_Ophd),
        .FETCH_REQ       (FETCH_REQ),
        .CM1             (CM1),
        .DEC_ENABLE      (DEC_ENABLE),
        .XPT             (XPT),
        .notXPT          (notXPT),
        .ITABLE          (ITABLE),
        .notITABLE       (notITABLE),
        .XPT_OVF         (XPT_OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fetch = 1;
        m_xpt   = 0;
        m_it    = 8'h00;
        m_ovf   = 0;
    endtask

    // One clock edge of the sequencer, written from the behavioural rules.
    task automatic model_step();
        bit any_strobe;
        if (m_fetch) begin
            if (MEM_READY) begin
                m_it    = DIN;
                m_xpt   = 0;
                m_fetch = 0;
            end
        end else begin
            any_strobe = PR_Reset_XPT || P2_Set_CM1 || P2_Reset_ITABLE || Pa_Ophd;
            if (PR_Reset_XPT) m_xpt = 0;
            else if (MEM_READY && !any_strobe) begin
                if (m_xpt == 15) m_ovf = 1;
                else m_xpt = m_xpt + 1;
            end
            if (P2_Reset_ITABLE) m_it = 8'h00;
            if (P2_Set_CM1 || Pa_Ophd) m_fetch = 1;
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] e_x;
        logic [3:0] e_nx;
        logic [7:0] e_nit;
        e_x   = 4'(m_xpt);
        e_nx  = ~e_x;
        e_nit = ~m_it;
        check({tag, ".CM1"},        CM1,        m_fetch);
        check({tag, ".FETCH_REQ"},  FETCH_REQ,  m_fetch);
        check({tag, ".DEC_ENABLE"}, DEC_ENABLE, !m_fetch);
        check({tag, ".XPT"},        XPT,        e_x);
        check({tag, ".notXPT"},     notXPT,     e_nx);
        check({tag, ".ITABLE"},     ITABLE,     m_it);
        check({tag, ".notITABLE"},  notITABLE,  e_nit);
        check({tag, ".XPT_OVF"},    XPT_OVF,    m_ovf);
    endtask

    // Drive inputs (just after a negedge), take one rising edge, check at the next negedge.
    task automatic cyc(input string tag, input bit mr, input logic [7:0] din,
                       input bit prx, input bit scm, input bit rit, input bit oph);
        MEM_READY       = mr;
        DIN             = din;
        PR_Reset_XPT    = prx;
        P2_Set_CM1      = scm;
        P2_Reset_ITABLE = rit;
        Pa_Ophd         = oph;
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        check_all(tag);
    endtask

    initial begin
        notRESET = 0;
        DIN = 8'h00; MEM_READY = 0;
        PR_Reset_XPT = 0; P2_Set_CM1 = 0; P2_Reset_ITABLE = 0; Pa_Ophd = 0;
        model_reset();
        repeat (2) @(negedge CLK);
        check_all("reset");
        check("reset.notXPT_ones", notXPT, 4'hF);
        notRESET = 1;

        // first fetch and stepping
        cyc("fetch1b", 1, 8'h1B, 0, 0, 0, 0);
        check("itable_1b", ITABLE, 8'h1B);
        check("notitable_e4", notITABLE, 8'hE4);
        check("xpt0", XPT, 4'd0);
        cyc("step1", 1, 8'h00, 0, 0, 0, 0);
        check("xpt1", XPT, 4'd1);
        cyc("step2", 1, 8'h00, 0, 0, 0, 0);
        check("xpt2", XPT, 4'd2);
        cyc("step3", 1, 8'h00, 0, 0, 0, 0);

        // stall at 3
        cyc("stall_a", 0, 8'h00, 0, 0, 0, 0);
        cyc("stall_b", 0, 8'h00, 0, 0, 0, 0);
        check("stall_xpt3", XPT, 4'd3);
        check("stall_decen", DEC_ENABLE, 1'b1);
        cyc("resume4", 1, 8'h00, 0, 0, 0, 0);
        check("xpt4", XPT, 4'd4);
        cyc("step5", 1, 8'h00, 0, 0, 0, 0);

        // all strobes together at 5
        cyc("allstrb", 1, 8'h00, 1, 1, 1, 1);
        check("allstrb_xpt", XPT, 4'd0);
        check("allstrb_it", ITABLE, 8'h00);
        check("allstrb_cm1", CM1, 1'b1);

        // slow fetch
        for (int i = 0; i < 4; i++) cyc("fwait", 0, 8'h55, 1, 1, 1, 1);
        check("fwait_it", ITABLE, 8'h00);
        cyc("fetch1d", 1, 8'h1D, 0, 0, 0, 0);
        check("itable_1d", ITABLE, 8'h1D);
        check("fetch1d_xpt", XPT, 4'd0);

        // saturation
        for (int i = 0; i < 20; i++) cyc("sat", 1, 8'h00, 0, 0, 0, 0);
        check("sat_xpt", XPT, 4'd15);
        check("sat_ovf", XPT_OVF, 1'b1);
        cyc("refetch_req", 1, 8'h00, 0, 0, 0, 1);
        cyc("refetch", 1, 8'h2A, 0, 0, 0, 0);
        check("ovf_sticky", XPT_OVF, 1'b1);

        // async reset mid-EXEC at XPT=7
        for (int i = 0; i < 7; i++) cyc("to7", 1, 8'h00, 0, 0, 0, 0);
        check("xpt7", XPT, 4'd7);
        #2 notRESET = 0;
        #1 model_reset();
        check_all("async_rst");
        @(negedge CLK);
        notRESET = 1;
        check_all("rst_release");
        cyc("restart", 1, 8'h3C, 0, 0, 0, 0);
        check("restart_it", ITABLE, 8'h3C);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc("rand",
                ($urandom_range(0, 3) != 0),
                8'($urandom),
                ($urandom_range(0, 11) == 0),
                ($urandom_range(0, 11) == 0),
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 13) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
